// File: rtl/abro_input_conditioner.sv
// Two-channel synchroniser + debouncer feeding the A/B inputs of the ABRO FSM.
// Optional rejected-glitch counter is built when ABRO_COND_GLITCH_CNT_EN is defined.

// One debounce channel: two-flop synchroniser, counter-qualified level, rising-edge pulse.
//   state       | meaning
//   ST_STABLE   | synchronised input equals debounced level, counter at 0
//   ST_CHANGING | synchronised input differs from level, counter qualifying the change
module abro_cond_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_nxt,
    output logic o_pulse
`ifdef ABRO_COND_GLITCH_CNT_EN
    ,output logic o_glitch
`endif
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_differ;
    logic             w_glitch;

    assign w_differ = (r_sync2 != r_level);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_level_nxt & ~r_level;
        end
    end

    // The first differing edge already counts, so a change qualifies after exactly
    // DEBOUNCE_CYCLES consecutive differing edges.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_glitch    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_differ) begin
                    if (r_cnt == C_LAST) begin
                        w_level_nxt = r_sync2;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = ST_CHANGING;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_CHANGING: begin
                if (w_differ) begin
                    if (r_cnt == C_LAST) begin
                        w_level_nxt = r_sync2;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                    w_glitch    = 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    assign o_level     = r_level;
    assign o_level_nxt = w_level_nxt;
    assign o_pulse     = r_pulse;
`ifdef ABRO_COND_GLITCH_CNT_EN
    assign o_glitch    = w_glitch;
`else
    logic w_glitch_unused;
    assign w_glitch_unused = w_glitch;
`endif

endmodule

module abro_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_a_raw,
    input  logic i_b_raw,
    output logic o_a_level,
    output logic o_b_level,
    output logic o_a_pulse,
    output logic o_b_pulse,
    output logic o_both_level
`ifdef ABRO_COND_GLITCH_CNT_EN
    ,output logic [7:0] o_glitch_count
`endif
);

    logic w_a_level_nxt;
    logic w_b_level_nxt;
    logic r_both_level;

`ifdef ABRO_COND_GLITCH_CNT_EN
    logic       w_a_glitch;
    logic       w_b_glitch;
    logic [8:0] w_gc_sum;
    logic [7:0] r_glitch_count;
`endif

    abro_cond_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_raw       (i_a_raw),
        .o_level     (o_a_level),
        .o_level_nxt (w_a_level_nxt),
        .o_pulse     (o_a_pulse)
`ifdef ABRO_COND_GLITCH_CNT_EN
        ,.o_glitch   (w_a_glitch)
`endif
    );

    abro_cond_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_raw       (i_b_raw),
        .o_level     (o_b_level),
        .o_level_nxt (w_b_level_nxt),
        .o_pulse     (o_b_pulse)
`ifdef ABRO_COND_GLITCH_CNT_EN
        ,.o_glitch   (w_b_glitch)
`endif
    );

    // Built from next-state levels so it lines up with o_a_level/o_b_level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_both_level <= 1'b0;
        end else begin
            r_both_level <= w_a_level_nxt & w_b_level_nxt;
        end
    end

    assign o_both_level = r_both_level;

`ifdef ABRO_COND_GLITCH_CNT_EN
    assign w_gc_sum = 9'(r_glitch_count) + 9'(w_a_glitch) + 9'(w_b_glitch);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_glitch_count <= 8'd0;
        end else begin
            r_glitch_count <= (w_gc_sum > 9'd255) ? 8'hFF : w_gc_sum[7:0];
        end
    end

    assign o_glitch_count = r_glitch_count;
`endif

endmodule
